// File: rtl/char_text_renderer.sv
// char_text_renderer: 40x30 text-mode pixel renderer with inverse video and blinking cursor
module char_text_renderer #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DE_IN,
  input  logic        HS_IN,
  input  logic        VS_IN,
  input  logic [9:0]  X,
  input  logic [9:0]  Y,
  output logic [10:0] TXT_ADDR,
  output logic        TXT_EN,
  input  logic [7:0]  TXT_DO,
  output logic [10:0] ROM_ADDR,
  output logic        ROM_EN,
  input  logic [15:0] ROM_DO,
  input  logic [5:0]  CUR_COL,
  input  logic [4:0]  CUR_ROW,
  input  logic        CUR_ON,
  input  logic [11:0] FG_COLOR,
  input  logic [11:0] BG_COLOR,
  output logic [11:0] RGB,
  output logic        DE_OUT,
  output logic        HS_OUT,
  output logic        VS_OUT
);
  logic [5:0] col, row, cur_col, blink_cnt;
  logic [4:0] cur_row;
  logic       cur_en, blink_phase, vs_q, vs_rise, blink_last, in_range, cur_hit;
  logic [3:0] s1_px, s2_px, s3_px, s1_off, s2_off;
  logic [2:0] s1_sync, s2_sync, s3_sync;
  logic       s1_rng, s2_rng, s3_rng, s1_cur, s2_cur, s3_swap, pix;
  logic [11:0] rgb_next;

  assign col        = X[9:4];
  assign row        = Y[9:4];
  assign in_range   = DE_IN && col < 6'(COLS) && row < 6'(ROWS);
  assign cur_hit    = cur_en && blink_phase && col == cur_col && row == {1'b0, cur_row};
  assign vs_rise    = VS_IN && !vs_q;
  assign blink_last = blink_cnt == 6'(BLINK_FRAMES - 1);
  // Glyph rows are stored bottom-up, so offset 15 holds the top row of the cell
  assign ROM_ADDR   = {TXT_DO[6:0], s2_off};
  assign ROM_EN     = s2_rng;
  // Bit 15 is the leftmost pixel, so ~px indexes 15-px
  assign pix        = ROM_DO[~s3_px] ^ s3_swap;

  always_comb begin
    rgb_next = !s3_sync[2] ? 12'h000 : (s3_rng && pix) ? FG_COLOR : BG_COLOR;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vs_q <= 1'b0;
      cur_col <= '0;
      cur_row <= '0;
      cur_en <= 1'b0;
      blink_cnt <= '0;
      blink_phase <= 1'b1;
      TXT_ADDR <= '0;
      TXT_EN <= 1'b0;
      {s1_px, s1_off, s1_sync, s1_rng, s1_cur} <= '0;
      {s2_px, s2_off, s2_sync, s2_rng, s2_cur} <= '0;
      {s3_px, s3_sync, s3_rng, s3_swap} <= '0;
      {RGB, DE_OUT, HS_OUT, VS_OUT} <= '0;
    end else begin
      vs_q <= VS_IN;
      if (vs_rise) begin
        cur_col <= CUR_COL;
        cur_row <= CUR_ROW;
        cur_en <= CUR_ON;
        blink_cnt <= blink_last ? 6'd0 : blink_cnt + 6'd1;
        if (blink_last) blink_phase <= ~blink_phase;
      end
      TXT_EN <= in_range;
      if (in_range) TXT_ADDR <= 11'(row * COLS + col);
      s1_px <= X[3:0];
      s1_off <= ~Y[3:0];
      s1_sync <= {DE_IN, HS_IN, VS_IN};
      s1_rng <= in_range;
      s1_cur <= cur_hit;
      s2_px <= s1_px;
      s2_off <= s1_off;
      s2_sync <= s1_sync;
      s2_rng <= s1_rng;
      s2_cur <= s1_cur;
      s3_px <= s2_px;
      s3_sync <= s2_sync;
      s3_rng <= s2_rng;
      s3_swap <= TXT_DO[7] ^ s2_cur;
      RGB <= rgb_next;
      {DE_OUT, HS_OUT, VS_OUT} <= s3_sync;
    end
  end
endmodule

// File: tb/tb_char_text_renderer.sv
// tb_char_text_renderer: directed vector bench with text RAM and glyph ROM models
module tb_char_text_renderer;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h0A5;

  logic        CLK = 1'b0, RST = 1'b1, DE_IN = 1'b0, HS_IN = 1'b0, VS_IN = 1'b0, CUR_ON = 1'b0;
  logic [9:0]  X = '0, Y = '0;
  logic [10:0] TXT_ADDR, ROM_ADDR;
  logic        TXT_EN, ROM_EN, DE_OUT, HS_OUT, VS_OUT;
  logic [7:0]  txt_do = '0;
  logic [15:0] rom_do = '0;
  logic [5:0]  CUR_COL = '0;
  logic [4:0]  CUR_ROW = '0;
  logic [11:0] RGB;
  logic [7:0]  ram [0:2047];
  logic [15:0] rom [0:2047];
  int n_vec = 0, n_bad = 0;

  char_text_renderer #(.COLS(40), .ROWS(30), .BLINK_FRAMES(2)) dut (
    .CLK(CLK), .RST(RST), .DE_IN(DE_IN), .HS_IN(HS_IN), .VS_IN(VS_IN), .X(X), .Y(Y),
    .TXT_ADDR(TXT_ADDR), .TXT_EN(TXT_EN), .TXT_DO(txt_do),
    .ROM_ADDR(ROM_ADDR), .ROM_EN(ROM_EN), .ROM_DO(rom_do),
    .CUR_COL(CUR_COL), .CUR_ROW(CUR_ROW), .CUR_ON(CUR_ON),
    .FG_COLOR(FG), .BG_COLOR(BG), .RGB(RGB),
    .DE_OUT(DE_OUT), .HS_OUT(HS_OUT), .VS_OUT(VS_OUT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (TXT_EN) txt_do <= ram[TXT_ADDR];
    if (ROM_EN) rom_do <= rom[ROM_ADDR];
  end

  typedef struct {
    logic [9:0]  x, y;
    logic        de, en;
    logic [10:0] taddr, raddr;
    logic [11:0] rgb;
  } vec_t;
  vec_t v [13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK) RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic pulse_vs();
    @(negedge CLK) VS_IN = 1'b1;
    @(negedge CLK) VS_IN = 1'b0;
  endtask

  task automatic pixel(input logic [9:0] px, input logic [9:0] py, output logic [11:0] rgb);
    @(negedge CLK);
    X = px; Y = py; DE_IN = 1'b1;
    @(negedge CLK) DE_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1 rgb = RGB;
  endtask

  initial begin
    logic [11:0] r;
    for (int i = 0; i < 2048; i++) begin ram[i] = 8'h00; rom[i] = 16'h0000; end
    ram[42] = 8'h41;
    ram[43] = 8'hC1;
    ram[1199] = 8'h05;
    rom[11'h41D] = 16'h8001;
    rom[11'h050] = 16'h0001;
    v[0]  = '{10'd32,  10'd18,  1'b1, 1'b1, 11'd42,   11'h41D, FG};
    v[1]  = '{10'd47,  10'd18,  1'b1, 1'b1, 11'd42,   11'h41D, FG};
    v[2]  = '{10'd33,  10'd18,  1'b1, 1'b1, 11'd42,   11'h41D, BG};
    v[3]  = '{10'd40,  10'd18,  1'b1, 1'b1, 11'd42,   11'h41D, BG};
    v[4]  = '{10'd46,  10'd18,  1'b1, 1'b1, 11'd42,   11'h41D, BG};
    v[5]  = '{10'd48,  10'd18,  1'b1, 1'b1, 11'd43,   11'h41D, BG};
    v[6]  = '{10'd49,  10'd18,  1'b1, 1'b1, 11'd43,   11'h41D, FG};
    v[7]  = '{10'd640, 10'd18,  1'b1, 1'b0, 11'd43,   11'h000, BG};
    v[8]  = '{10'd32,  10'd480, 1'b1, 1'b0, 11'd43,   11'h000, BG};
    v[9]  = '{10'd32,  10'd18,  1'b0, 1'b0, 11'd43,   11'h000, 12'h000};
    v[10] = '{10'd0,   10'd0,   1'b1, 1'b1, 11'd0,    11'h00F, BG};
    v[11] = '{10'd639, 10'd479, 1'b1, 1'b1, 11'd1199, 11'h050, FG};
    v[12] = '{10'd624, 10'd479, 1'b1, 1'b1, 11'd1199, 11'h050, BG};

    repeat (2) @(negedge CLK);
    check("reset rgb", RGB, 12'h000);
    check("reset syncs", {DE_OUT, HS_OUT, VS_OUT}, 3'b000);
    check("reset txt", {TXT_EN, TXT_ADDR}, 12'h000);
    RST = 1'b0;

    repeat (9) @(negedge CLK);
    DE_IN = 1'b1; HS_IN = 1'b1; VS_IN = 1'b1; X = 10'd32; Y = 10'd18;
    for (int k = 1; k <= 5; k++) begin
      @(posedge CLK); #1;
      check($sformatf("align de_out e%0d", k), DE_OUT, (k == 4));
      check($sformatf("align hs_out e%0d", k), HS_OUT, (k == 4));
      check($sformatf("align vs_out e%0d", k), VS_OUT, (k == 4));
      if (k == 4) check("align rgb", RGB, FG);
      if (k == 5) check("rgb outside de", RGB, 12'h000);
      if (k == 1) begin
        @(negedge CLK);
        DE_IN = 1'b0; HS_IN = 1'b0; VS_IN = 1'b0;
      end
    end

    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      X = v[i].x; Y = v[i].y; DE_IN = v[i].de;
      @(posedge CLK); #1;
      check($sformatf("txt_en[%0d]", i), TXT_EN, v[i].en);
      check($sformatf("txt_addr[%0d]", i), TXT_ADDR, v[i].taddr);
      @(negedge CLK) DE_IN = 1'b0;
      @(posedge CLK); #1;
      check($sformatf("rom_en[%0d]", i), ROM_EN, v[i].en);
      if (v[i].en) check($sformatf("rom_addr[%0d]", i), ROM_ADDR, v[i].raddr);
      repeat (2) @(posedge CLK);
      #1;
      check($sformatf("rgb[%0d]", i), RGB, v[i].rgb);
      check($sformatf("de_out[%0d]", i), DE_OUT, v[i].de);
    end

    do_reset();
    CUR_ON = 1'b1; CUR_COL = 6'd2; CUR_ROW = 5'd1;
    pixel(10'd33, 10'd18, r); check("cursor before vs", r, BG);
    pulse_vs(); pixel(10'd33, 10'd18, r); check("blink frame1", r, FG);
    pulse_vs(); pixel(10'd33, 10'd18, r); check("blink frame2", r, BG);
    pulse_vs(); pixel(10'd33, 10'd18, r); check("blink frame3", r, BG);
    pulse_vs(); pixel(10'd33, 10'd18, r); check("blink frame4", r, FG);
    CUR_COL = 6'd3;
    pixel(10'd33, 10'd18, r); check("cursor midframe hold", r, FG);
    pulse_vs(); pixel(10'd33, 10'd18, r); check("cursor old cell", r, BG);
    pixel(10'd49, 10'd18, r); check("cursor on inverse", r, BG);
    pulse_vs(); pixel(10'd49, 10'd18, r); check("blink frame6", r, FG);

    @(negedge CLK);
    X = 10'd32; Y = 10'd18; DE_IN = 1'b1;
    repeat (5) @(posedge CLK);
    #1 check("stream before reset", RGB, FG);
    #1 RST = 1'b1;
    #1;
    check("async reset rgb", RGB, 12'h000);
    check("async reset de_out", DE_OUT, 1'b0);
    @(negedge CLK) RST = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK); #1;
      check($sformatf("resume rgb e%0d", k), RGB, (k == 4) ? FG : 12'h000);
    end
    DE_IN = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
